// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned INST_BYTES = 4;

   typedef enum logic [1:0] {
      StFetch   = 2'd0,
      StWait    = 2'd1,
      StDiscard = 2'd2
   } fetch_state_e;

   // Buffer entry layout for the default 32-bit configuration; the top level
   // declares the same {inst, pc} layout at its own parameter widths.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer: push/pop/flush with a combinational head read.
module fetch_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         data_i,
   output logic [Width-1:0]         data_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) tail_d = tail_q + PtrW'(1);
         if (pop_i)  head_d = head_q + PtrW'(1);
         if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
         end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[tail_q] <= data_i;
   end

   assign data_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding icache request FSM, prioritised
// redirect mux and fetch buffer feeding the instruction queue.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   output logic              icache_req_valid_out,
   output logic [ADDR_W-1:0] icache_req_addr_out,
   input  logic              icache_req_ready_in,
   input  logic              icache_resp_valid_in,
   input  logic [INST_W-1:0] icache_resp_inst_in,
   output logic              if_instqueue_valid_out,
   output logic [INST_W-1:0] if_instqueue_inst_out,
   output logic [ADDR_W-1:0] if_instqueue_pc_out,
   input  logic              instqueue_if_ready_in,
   input  logic              rob_if_en_in,
   input  logic [ADDR_W-1:0] rob_if_pc_in,
   input  logic              decoder_if_en_in,
   input  logic [ADDR_W-1:0] decoder_if_addr_in,
   input  logic              bp_if_en_in,
   input  logic [ADDR_W-1:0] bp_if_pc_in
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              run_q;
   logic              redir;
   logic [ADDR_W-1:0] redir_target;
   logic [CntW-1:0]   count;
   logic              buf_nonempty;
   logic              req_fire, resp_fire, push, pop, flush;
   entry_t            push_entry, head_entry;

   assign redir = rob_if_en_in | decoder_if_en_in | bp_if_en_in;

   always_comb begin
      redir_target = bp_if_pc_in;
      if (rob_if_en_in) begin
         redir_target = rob_if_pc_in;
      end else if (decoder_if_en_in) begin
         redir_target = decoder_if_addr_in;
      end
      redir_target[1:0] = 2'b00;
   end

   // run_q keeps the request low through the reset cycle itself.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (rdy_in) begin
         case (state_q)
            StFetch: begin
               if (req_fire) state_d = redir ? StDiscard : StWait;
            end
            StWait: begin
               if (icache_resp_valid_in) begin
                  state_d = StFetch;
                  if (!redir) pc_d = pc_q + ADDR_W'(INST_BYTES);
               end else if (redir) begin
                  state_d = StDiscard;
               end
            end
            StDiscard: begin
               if (icache_resp_valid_in) state_d = StFetch;
            end
            default: state_d = StFetch;
         endcase
         if (redir) pc_d = redir_target;
      end
   end

   always_comb begin
      buf_nonempty           = (count != '0);
      icache_req_valid_out   = rdy_in && run_q && (state_q == StFetch) && (count < CntW'(DEPTH));
      icache_req_addr_out    = pc_q;
      if_instqueue_valid_out = rdy_in && buf_nonempty && !redir;
      if_instqueue_inst_out  = buf_nonempty ? head_entry.inst : '0;
      if_instqueue_pc_out    = buf_nonempty ? head_entry.pc : '0;
      req_fire   = icache_req_valid_out && icache_req_ready_in;
      resp_fire  = rdy_in && icache_resp_valid_in;
      push       = resp_fire && (state_q == StWait) && !redir;
      pop        = if_instqueue_valid_out && instqueue_if_ready_in;
      flush      = rdy_in && redir;
      push_entry = '{inst: icache_resp_inst_in, pc: pc_q};
   end

   fetch_fifo #(
      .Width (INST_W + ADDR_W),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_ni  (rst_n_in),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_entry),
      .data_o  (head_entry),
      .count_o (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable icache responder.
module tb_fetch_unit;

   logic        clk_in;
   logic        rst_n_in;
   logic        rdy_in;
   logic        icache_req_valid_out;
   logic [31:0] icache_req_addr_out;
   logic        icache_req_ready_in;
   logic        icache_resp_valid_in;
   logic [31:0] icache_resp_inst_in;
   logic        if_instqueue_valid_out;
   logic [31:0] if_instqueue_inst_out;
   logic [31:0] if_instqueue_pc_out;
   logic        instqueue_if_ready_in;
   logic        rob_if_en_in;
   logic [31:0] rob_if_pc_in;
   logic        decoder_if_en_in;
   logic [31:0] decoder_if_addr_in;
   logic        bp_if_en_in;
   logic [31:0] bp_if_pc_in;

   int          checks;
   int          errors;
   int          lat;
   int          pend_cnt;
   logic [31:0] pend_addr;
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];

   fetch_unit #(
      .ADDR_W   (32),
      .INST_W   (32),
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk_in                 (clk_in),
      .rst_n_in               (rst_n_in),
      .rdy_in                 (rdy_in),
      .icache_req_valid_out   (icache_req_valid_out),
      .icache_req_addr_out    (icache_req_addr_out),
      .icache_req_ready_in    (icache_req_ready_in),
      .icache_resp_valid_in   (icache_resp_valid_in),
      .icache_resp_inst_in    (icache_resp_inst_in),
      .if_instqueue_valid_out (if_instqueue_valid_out),
      .if_instqueue_inst_out  (if_instqueue_inst_out),
      .if_instqueue_pc_out    (if_instqueue_pc_out),
      .instqueue_if_ready_in  (instqueue_if_ready_in),
      .rob_if_en_in           (rob_if_en_in),
      .rob_if_pc_in           (rob_if_pc_in),
      .decoder_if_en_in       (decoder_if_en_in),
      .decoder_if_addr_in     (decoder_if_addr_in),
      .bp_if_en_in            (bp_if_en_in),
      .bp_if_pc_in            (bp_if_pc_in)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Icache: answers `lat` cycles after an accept with inst = addr ^ 0xA5A5.
   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         pend_cnt = 0;
         icache_resp_valid_in = 1'b0;
      end else begin
         icache_resp_valid_in = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               icache_resp_valid_in = 1'b1;
               icache_resp_inst_in  = pend_addr ^ 32'hA5A5;
            end
         end
         if (icache_req_valid_out && icache_req_ready_in) begin
            pend_addr = icache_req_addr_out;
            pend_cnt  = lat;
         end
      end
   end

   // Records every instruction the queue consumes.
   always @(negedge clk_in) begin
      if (if_instqueue_valid_out && instqueue_if_ready_in) begin
         got_pc.push_back(if_instqueue_pc_out);
         got_inst.push_back(if_instqueue_inst_out);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (icache_req_valid_out !== 1'b0) begin
         errors++; $display("FAIL reset_req_valid got %b exp 0", icache_req_valid_out);
      end
      checks++;
      if (icache_req_addr_out !== 32'h100) begin
         errors++; $display("FAIL reset_addr got %h exp 00000100", icache_req_addr_out);
      end
      checks++;
      if (if_instqueue_valid_out !== 1'b0) begin
         errors++; $display("FAIL reset_q_valid got %b exp 0", if_instqueue_valid_out);
      end
      checks++;
      if (if_instqueue_pc_out !== 32'h0 || if_instqueue_inst_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_q_data got pc %h inst %h exp 0 0",
                  if_instqueue_pc_out, if_instqueue_inst_out);
      end
      icache_req_ready_in = 1'b1;
      rst_n_in = 1'b1;
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h100) begin
         errors++;
         $display("FAIL first_req got v %b addr %h exp 1 00000100",
                  icache_req_valid_out, icache_req_addr_out);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc;
      instqueue_if_ready_in = 1'b1;
      tick(2);
      checks++;
      if (if_instqueue_valid_out !== 1'b1 || if_instqueue_pc_out !== 32'h100 ||
          if_instqueue_inst_out !== 32'hA4A5) begin
         errors++;
         $display("FAIL stream_latency got v %b pc %h inst %h exp 1 00000100 0000a4a5",
                  if_instqueue_valid_out, if_instqueue_pc_out, if_instqueue_inst_out);
      end
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h104) begin
         errors++;
         $display("FAIL stream_next_req got v %b addr %h exp 1 00000104",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(5);
      for (int i = 0; i < 3; i++) begin
         exp_pc = 32'h100 + 32'(4 * i);
         checks++;
         if (got_pc.size() <= i) begin
            errors++; $display("FAIL stream_order[%0d] got none exp pc %h", i, exp_pc);
         end else if (got_pc[i] !== exp_pc || got_inst[i] !== (exp_pc ^ 32'hA5A5)) begin
            errors++;
            $display("FAIL stream_order[%0d] got pc %h inst %h exp %h %h",
                     i, got_pc[i], got_inst[i], exp_pc, exp_pc ^ 32'hA5A5);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      instqueue_if_ready_in = 1'b0;
      tick(20);
      checks++;
      if (icache_req_valid_out !== 1'b0 || if_instqueue_valid_out !== 1'b1 ||
          if_instqueue_pc_out !== 32'h10C) begin
         errors++;
         $display("FAIL full_stall got req %b qv %b head %h exp 0 1 0000010c",
                  icache_req_valid_out, if_instqueue_valid_out, if_instqueue_pc_out);
      end
      instqueue_if_ready_in = 1'b1;
      tick(1);
      instqueue_if_ready_in = 1'b0;
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h11C) begin
         errors++;
         $display("FAIL pop_reopens got v %b addr %h exp 1 0000011c",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(3);
      checks++;
      if (icache_req_valid_out !== 1'b0) begin
         errors++; $display("FAIL refull_stall got %b exp 0", icache_req_valid_out);
      end
      got_pc.delete();
      got_inst.delete();
      icache_req_ready_in   = 1'b0;
      instqueue_if_ready_in = 1'b1;
      tick(8);
      instqueue_if_ready_in = 1'b0;
      checks++;
      if (got_pc.size() != 4) begin
         errors++; $display("FAIL drain_count got %0d exp 4", got_pc.size());
      end
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'h110 + 32'(4 * i);
         checks++;
         if (got_pc.size() <= i) begin
            errors++; $display("FAIL drain[%0d] got none exp pc %h", i, exp_pc);
         end else if (got_pc[i] !== exp_pc || got_inst[i] !== (exp_pc ^ 32'hA5A5)) begin
            errors++;
            $display("FAIL drain[%0d] got pc %h inst %h exp %h %h",
                     i, got_pc[i], got_inst[i], exp_pc, exp_pc ^ 32'hA5A5);
         end
      end
   endtask

   task automatic test_priority();
      icache_req_ready_in = 1'b1;
      tick(5);
      icache_req_ready_in = 1'b0;
      tick(3);
      checks++;
      if (if_instqueue_valid_out !== 1'b1) begin
         errors++; $display("FAIL prio_prefill got %b exp 1", if_instqueue_valid_out);
      end
      rob_if_en_in = 1'b1;     rob_if_pc_in = 32'h200;
      decoder_if_en_in = 1'b1; decoder_if_addr_in = 32'h300;
      bp_if_en_in = 1'b1;      bp_if_pc_in = 32'h400;
      #1;
      checks++;
      if (if_instqueue_valid_out !== 1'b0) begin
         errors++; $display("FAIL prio_valid_masked got %b exp 0", if_instqueue_valid_out);
      end
      tick(1);
      rob_if_en_in = 1'b0;
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h200) begin
         errors++;
         $display("FAIL prio_rob got v %b addr %h exp 1 00000200",
                  icache_req_valid_out, icache_req_addr_out);
      end
      checks++;
      if (if_instqueue_valid_out !== 1'b1 - 1'b1) begin
         errors++; $display("FAIL prio_flush got %b exp 0", if_instqueue_valid_out);
      end
      tick(1);
      decoder_if_en_in = 1'b0;
      bp_if_en_in = 1'b0;
      checks++;
      if (icache_req_addr_out !== 32'h300) begin
         errors++; $display("FAIL prio_dec_over_bp got %h exp 00000300", icache_req_addr_out);
      end
   endtask

   task automatic test_stale();
      decoder_if_en_in = 1'b1; decoder_if_addr_in = 32'h10C;
      tick(1);
      decoder_if_en_in = 1'b0;
      checks++;
      if (icache_req_addr_out !== 32'h10C) begin
         errors++; $display("FAIL stale_setup got %h exp 0000010c", icache_req_addr_out);
      end
      got_pc.delete();
      got_inst.delete();
      lat = 3;
      icache_req_ready_in   = 1'b1;
      instqueue_if_ready_in = 1'b1;
      tick(1);
      icache_req_ready_in = 1'b0;
      rob_if_en_in = 1'b1; rob_if_pc_in = 32'h500;
      tick(1);
      rob_if_en_in = 1'b0;
      checks++;
      if (icache_req_valid_out !== 1'b0) begin
         errors++; $display("FAIL stale_hold1 got %b exp 0", icache_req_valid_out);
      end
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b0) begin
         errors++; $display("FAIL stale_hold2 got %b exp 0", icache_req_valid_out);
      end
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h500) begin
         errors++;
         $display("FAIL stale_resume got v %b addr %h exp 1 00000500",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(3);
      checks++;
      if (got_pc.size() != 0 || if_instqueue_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL stale_dropped got n %0d qv %b exp 0 0",
                  got_pc.size(), if_instqueue_valid_out);
      end
   endtask

   task automatic test_races();
      lat = 1;
      icache_req_ready_in = 1'b1;
      tick(1);
      icache_req_ready_in = 1'b0;
      rob_if_en_in = 1'b1; rob_if_pc_in = 32'h500;
      tick(1);
      rob_if_en_in = 1'b0;
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h500 ||
          if_instqueue_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL race_resp got v %b addr %h qv %b exp 1 00000500 0",
                  icache_req_valid_out, icache_req_addr_out, if_instqueue_valid_out);
      end
      icache_req_ready_in = 1'b1;
      rob_if_en_in = 1'b1; rob_if_pc_in = 32'h700;
      tick(1);
      rob_if_en_in = 1'b0;
      icache_req_ready_in = 1'b0;
      checks++;
      if (icache_req_valid_out !== 1'b0 || icache_req_addr_out !== 32'h700) begin
         errors++;
         $display("FAIL race_accept_discard got v %b addr %h exp 0 00000700",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h700) begin
         errors++;
         $display("FAIL race_accept_resume got v %b addr %h exp 1 00000700",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(2);
      checks++;
      if (if_instqueue_valid_out !== 1'b0 || got_pc.size() != 0) begin
         errors++;
         $display("FAIL race_stale_dropped got qv %b n %0d exp 0 0",
                  if_instqueue_valid_out, got_pc.size());
      end
      instqueue_if_ready_in = 1'b0;
   endtask

   task automatic test_misaligned_gating();
      bp_if_en_in = 1'b1; bp_if_pc_in = 32'h603;
      tick(1);
      bp_if_en_in = 1'b0;
      checks++;
      if (icache_req_addr_out !== 32'h600) begin
         errors++; $display("FAIL misaligned got %h exp 00000600", icache_req_addr_out);
      end
      icache_req_ready_in = 1'b1;
      tick(4);
      icache_req_ready_in = 1'b0;
      rdy_in = 1'b0;
      rob_if_en_in = 1'b1; rob_if_pc_in = 32'h900;
      instqueue_if_ready_in = 1'b1;
      icache_req_ready_in = 1'b1;
      #1;
      checks++;
      if (icache_req_valid_out !== 1'b0 || if_instqueue_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL rdy_low_outputs got req %b qv %b exp 0 0",
                  icache_req_valid_out, if_instqueue_valid_out);
      end
      tick(5);
      rdy_in = 1'b1;
      rob_if_en_in = 1'b0;
      instqueue_if_ready_in = 1'b0;
      icache_req_ready_in = 1'b0;
      #1;
      checks++;
      if (icache_req_addr_out !== 32'h608 || if_instqueue_valid_out !== 1'b1 ||
          if_instqueue_pc_out !== 32'h600 || if_instqueue_inst_out !== 32'hA3A5) begin
         errors++;
         $display("FAIL rdy_low_hold got addr %h qv %b pc %h inst %h exp 00000608 1 00000600 0000a3a5",
                  icache_req_addr_out, if_instqueue_valid_out,
                  if_instqueue_pc_out, if_instqueue_inst_out);
      end
   endtask

   task automatic test_midstream_reset();
      tick(1);
      icache_req_ready_in = 1'b1;
      tick(1);
      icache_req_ready_in = 1'b0;
      rst_n_in = 1'b0;
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b0 || if_instqueue_valid_out !== 1'b0 ||
          icache_req_addr_out !== 32'h100 || if_instqueue_pc_out !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset got req %b qv %b addr %h pc %h exp 0 0 00000100 0",
                  icache_req_valid_out, if_instqueue_valid_out,
                  icache_req_addr_out, if_instqueue_pc_out);
      end
      rst_n_in = 1'b1;
      tick(1);
      checks++;
      if (icache_req_valid_out !== 1'b1 || icache_req_addr_out !== 32'h100) begin
         errors++;
         $display("FAIL mid_reset_release got v %b addr %h exp 1 00000100",
                  icache_req_valid_out, icache_req_addr_out);
      end
      tick(2);
      checks++;
      if (if_instqueue_valid_out !== 1'b0) begin
         errors++; $display("FAIL mid_reset_no_stale got %b exp 0", if_instqueue_valid_out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      lat = 1;
      pend_cnt = 0;
      pend_addr = '0;
      rst_n_in = 1'b0;
      rdy_in = 1'b1;
      icache_req_ready_in = 1'b0;
      icache_resp_valid_in = 1'b0;
      icache_resp_inst_in = '0;
      instqueue_if_ready_in = 1'b0;
      rob_if_en_in = 1'b0;     rob_if_pc_in = '0;
      decoder_if_en_in = 1'b0; decoder_if_addr_in = '0;
      bp_if_en_in = 1'b0;      bp_if_pc_in = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_priority();
      test_stale();
      test_races();
      test_misaligned_gating();
      test_midstream_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
